// File: rtl/regfile_sb.sv
// Register file with a pending-write scoreboard.
// After reset an INIT sweep writes zero into every register, one per cycle,
// then the block enters RUN. Reads are combinational with optional
// same-cycle write forwarding. A busy bit per register tracks
// issued-but-not-yet-written destinations.
// Interface timing: there is no valid/ready handshake. A write (i_we) or an
// issue (i_issue) is accepted on every rising edge where it is asserted while
// o_ready is high; while o_ready is low both are dropped, but i_flush is
// always accepted.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd,
  input  logic [AW-1:0]         i_rs1_addr,
  input  logic [AW-1:0]         i_rs2_addr,
  output logic [DATA_WIDTH-1:0] o_rs1,
  output logic [DATA_WIDTH-1:0] o_rs2,
  input  logic                  i_issue,
  input  logic [AW-1:0]         i_issue_addr,
  input  logic                  i_flush,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_ready,
  output logic                  o_dbg_state
);

  localparam logic [AW:0]   REG_LIMIT = (AW + 1)'(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t                state, state_next;
  logic [AW-1:0]         count, count_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy, busy_next;

  logic run;
  logic wr_en, iss_en;
  logic rs1_ok, rs2_ok, rs1_hit, rs2_hit;

  // An address is usable when it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < REG_LIMIT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run         = (state == S_RUN);
  assign o_ready     = run;
  assign o_dbg_state = state;
  assign wr_en       = run && i_we && addr_ok(i_rd_addr);
  assign iss_en      = run && i_issue && addr_ok(i_issue_addr);

  // State and sweep counter; reset restarts the full sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_INIT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state: advance the sweep, leave INIT after the last register.
  always_comb begin
    state_next = state;
    count_next = count;
    if (state == S_INIT) begin
      count_next = count + 1'b1;
      if (count == LAST_IDX) begin
        state_next = S_RUN;
        count_next = '0;
      end
    end
  end

  // Storage has no reset; INIT clears one register per cycle.
  always_ff @(posedge i_clk) begin
    if (!run) begin
      regs[count] <= '0;
    end else if (wr_en) begin
      regs[i_rd_addr] <= i_rd;
    end
  end

  // Busy update: flush clears all, a write clears its bit, issue sets last so it wins.
  always_comb begin
    busy_next = busy;
    if (i_flush) busy_next = '0;
    if (wr_en)   busy_next[i_rd_addr] = 1'b0;
    if (iss_en)  busy_next[i_issue_addr] = 1'b1;
  end

  // Busy vector register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy <= '0;
    else          busy <= busy_next;
  end

  assign rs1_ok  = addr_ok(i_rs1_addr);
  assign rs2_ok  = addr_ok(i_rs2_addr);
  assign rs1_hit = (BYPASS != 0) && wr_en && (i_rd_addr == i_rs1_addr);
  assign rs2_hit = (BYPASS != 0) && wr_en && (i_rd_addr == i_rs2_addr);

  assign o_rs1 = !(run && rs1_ok) ? '0 : (rs1_hit ? i_rd : regs[i_rs1_addr]);
  assign o_rs2 = !(run && rs2_ok) ? '0 : (rs2_hit ? i_rd : regs[i_rs2_addr]);

  assign o_rs1_busy = rs1_ok && busy[i_rs1_addr] && !rs1_hit;
  assign o_rs2_busy = rs2_ok && busy[i_rs2_addr] && !rs2_hit;

endmodule
